tdc_result_packer: RTL and testbench



---
 rtl/tdc_pkg.sv | 27 ++
 rtl/tdc_result_packer_if.sv | 31 +++
 rtl/tdc_res_fifo.sv | 53 +++++
 rtl/tdc_result_packer.sv | 155 +++++++++++++++
 tb/tb_tdc_result_packer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tdc_pkg.sv
// -----------------------------------------------------------------------------
// tdc_pkg
// Shared definitions for the tdc_top result stream and the result packer:
// beat field widths, result word layout and the packer FSM state encoding.
// -----------------------------------------------------------------------------
package tdc_pkg;

  localparam int TDC_DATA_W = 15;
  localparam int TDC_INT_W  = 5;
  localparam int TDC_NUM_W  = 2;

  localparam int RES_W      = 32;
  localparam int SUM_W      = 8;
  localparam int CNT_W      = 4;

  // Result word: {best_data, best_int, int_sum, hit_cnt}
  localparam int RES_DATA_LSB = 17;
  localparam int RES_INT_LSB  = 12;
  localparam int RES_SUM_LSB  = 4;
  localparam int RES_CNT_LSB  = 0;

  typedef enum logic {
    ACCUM = 1'b0,
    PUSH  = 1'b1
  } state_e;

endpackage

// File: rtl/tdc_result_packer_if.sv
// -----------------------------------------------------------------------------
// tdc_result_packer_if
// Bundles the tdc_top beat stream (TDC_O*) and the packed-result pop port.
//   master : drives beats and pops results (tdc_top side + readout logic)
//   slave  : the packer; accepts beats, presents the result FIFO head
// -----------------------------------------------------------------------------
interface tdc_result_packer_if;
  import tdc_pkg::*;

  logic [TDC_DATA_W-1:0] TDC_Odata;
  logic [TDC_INT_W-1:0]  TDC_Oint;
  logic [TDC_NUM_W-1:0]  TDC_Onum;
  logic                  TDC_Olast;
  logic                  TDC_Ovalid;
  logic                  TDC_Oready;

  logic [RES_W-1:0]      res_data;
  logic                  res_valid;
  logic                  res_ready;

  modport master (
    output TDC_Odata, TDC_Oint, TDC_Onum, TDC_Olast, TDC_Ovalid, res_ready,
    input  TDC_Oready, res_data, res_valid
  );

  modport slave (
    input  TDC_Odata, TDC_Oint, TDC_Onum, TDC_Olast, TDC_Ovalid, res_ready,
    output TDC_Oready, res_data, res_valid
  );

endinterface

// File: rtl/tdc_res_fifo.sv
// -----------------------------------------------------------------------------
// tdc_res_fifo
// Synchronous show-ahead FIFO. dout presents the head entry combinationally
// (forced to 0 while empty). Pointers carry one extra wrap bit so full and
// empty are distinguished without a counter.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset (pointers only)
//   push, din, full : write side; push while full is ignored
//   pop, dout, empty: read side; pop while empty is ignored
// -----------------------------------------------------------------------------
module tdc_res_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/tdc_result_packer.sv
// -----------------------------------------------------------------------------
// tdc_result_packer
// Reduces each tdc_top frame (beats terminated by TDC_Olast) to one 32-bit
// word {best_data, best_int, int_sum, hit_cnt} and queues it in a show-ahead
// FIFO. TDC_Oready drops for one bubble cycle per frame while the finished
// word is written, and stays low while the FIFO is full.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : slave side of tdc_result_packer_if (beats in, results out)
//   frame_cnt : frames pushed into the FIFO, wraps at 2^16
// -----------------------------------------------------------------------------
module tdc_result_packer
  import tdc_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = TDC_DATA_W,
  parameter int INT_W      = TDC_INT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  tdc_result_packer_if.slave   bus,
  output logic [15:0]          frame_cnt
);

  function automatic logic [SUM_W-1:0] sat_sum(input logic [SUM_W-1:0] a,
                                                input logic [INT_W-1:0] b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + (SUM_W+1)'(b);
    return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] a,
                                                input logic [TDC_NUM_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  state_e             state_q, state_d;
  logic               oready_q;
  logic               beat_acc;
  logic               last_acc;
  logic               push_req;
  logic               fifo_full;
  logic               fifo_empty;

  logic [DATA_W-1:0]  best_data_q;
  logic [INT_W-1:0]   best_int_q;
  logic [SUM_W-1:0]   int_sum_q;
  logic [CNT_W-1:0]   hit_cnt_q;
  logic               first_q;
  logic [RES_W-1:0]   pend_q;

  logic               take_best;
  logic [DATA_W-1:0]  nb_data;
  logic [INT_W-1:0]   nb_int;
  logic [SUM_W-1:0]   n_sum;
  logic [CNT_W-1:0]   n_cnt;

  assign bus.TDC_Oready = oready_q;
  assign bus.res_valid  = ~fifo_empty;
  assign last_acc       = beat_acc & bus.TDC_Olast;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  // FSM: next state; the full check uses the registered flag, so a pop in
  // the same cycle only frees the slot for the following edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (last_acc)   state_d = PUSH;
      PUSH:    if (!fifo_full) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // FSM: outputs
  always_comb begin
    beat_acc = 1'b0;
    push_req = 1'b0;
    case (state_q)
      ACCUM:   beat_acc = bus.TDC_Ovalid & oready_q;
      PUSH:    push_req = ~fifo_full;
      default: ;
    endcase
  end

  // Ready is registered from the next state so it tracks ACCUM one cycle on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) oready_q <= 1'b0;
    else     oready_q <= (state_d == ACCUM);
  end

  // First beat of a frame loads unconditionally; ties keep the earlier beat
  assign take_best = first_q | (bus.TDC_Oint > best_int_q);
  assign nb_data   = take_best ? bus.TDC_Odata : best_data_q;
  assign nb_int    = take_best ? bus.TDC_Oint  : best_int_q;
  assign n_sum     = sat_sum(int_sum_q, bus.TDC_Oint);
  assign n_cnt     = sat_cnt(hit_cnt_q, bus.TDC_Onum);

  // Stage p0: accumulate beats, latch the finished word on Olast
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_data_q <= '0;
      best_int_q  <= '0;
      int_sum_q   <= '0;
      hit_cnt_q   <= '0;
      first_q     <= 1'b1;
      pend_q      <= '0;
    end else if (beat_acc) begin
      if (bus.TDC_Olast) begin
        pend_q[RES_DATA_LSB +: DATA_W] <= nb_data;
        pend_q[RES_INT_LSB  +: INT_W]  <= nb_int;
        pend_q[RES_SUM_LSB  +: SUM_W]  <= n_sum;
        pend_q[RES_CNT_LSB  +: CNT_W]  <= n_cnt;
        best_data_q <= '0;
        best_int_q  <= '0;
        int_sum_q   <= '0;
        hit_cnt_q   <= '0;
        first_q     <= 1'b1;
      end else begin
        best_data_q <= nb_data;
        best_int_q  <= nb_int;
        int_sum_q   <= n_sum;
        hit_cnt_q   <= n_cnt;
        first_q     <= 1'b0;
      end
    end
  end

  // Stage p1: write the finished word into the result FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           frame_cnt <= '0;
    else if (push_req) frame_cnt <= frame_cnt + 16'd1;
  end

  tdc_res_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (pend_q),
    .full  (fifo_full),
    .pop   (bus.res_ready),
    .dout  (bus.res_data),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_tdc_result_packer.sv
// -----------------------------------------------------------------------------
// tb_tdc_result_packer
// Drives tdc_top-style beat frames into tdc_result_packer and checks the packed
// result words against a queue of expected words, plus ready/valid/frame_cnt
// behaviour across backpressure, bubble and reset sequences.
// -----------------------------------------------------------------------------
module tb_tdc_result_packer;

  logic        clk;
  logic        rst;
  logic [15:0] frame_cnt;
  int          checks;
  int          failures;
  logic [31:0] exp_q [$];

  tdc_result_packer_if bus ();

  tdc_result_packer #(
    .FIFO_DEPTH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .frame_cnt (frame_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [14:0] d;
    logic [4:0]  i;
    logic [1:0]  n;
    logic [14:0] ed;
    logic [4:0]  ei;
    logic [7:0]  es;
    logic [3:0]  ec;
  } vec_t;

  vec_t tbl [4];

  function automatic logic [31:0] pack(input logic [14:0] d, input logic [4:0] i,
                                       input logic [7:0] s, input logic [3:0] c);
    return {d, i, s, c};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Scoreboard: every pop (valid & ready seen away from the edge) is compared
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", bus.res_data, 32'hDEAD_BEEF);
      end else begin
        chk("res_word", bus.res_data, exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted
  task automatic drive_beat(input logic [14:0] d, input logic [4:0] i,
                            input logic [1:0] n, input logic l);
    int w;
    w = 0;
    bus.TDC_Odata  = d;
    bus.TDC_Oint   = i;
    bus.TDC_Onum   = n;
    bus.TDC_Olast  = l;
    bus.TDC_Ovalid = 1'b1;
    @(negedge clk);
    while (!bus.TDC_Oready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.TDC_Oready) chk("beat_timeout", 32'(w), 32'd0);
    @(posedge clk);
    #1;
    bus.TDC_Ovalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.res_valid) && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.TDC_Odata  = '0;
    bus.TDC_Oint   = '0;
    bus.TDC_Onum   = '0;
    bus.TDC_Olast  = 1'b0;
    bus.TDC_Ovalid = 1'b0;
    bus.res_ready  = 1'b0;

    tbl[0] = '{15'h7FFF, 5'd31, 2'd3, 15'h7FFF, 5'd31, 8'd31, 4'd3};
    tbl[1] = '{15'd0,    5'd0,  2'd0, 15'd0,    5'd0,  8'd0,  4'd0};
    tbl[2] = '{15'd1234, 5'd17, 2'd2, 15'd1234, 5'd17, 8'd17, 4'd2};
    tbl[3] = '{15'd42,   5'd1,  2'd1, 15'd42,   5'd1,  8'd1,  4'd1};

    // Reset values
    @(negedge clk);
    chk("rst_oready",    32'(bus.TDC_Oready), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid),  32'd0);
    chk("rst_res_data",  bus.res_data,        32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt),      32'd0);
    rst = 1'b0;
    #1;
    chk("oready_pre_edge", 32'(bus.TDC_Oready), 32'd0);
    @(negedge clk);
    chk("oready_first_edge", 32'(bus.TDC_Oready), 32'd1);
    @(posedge clk);
    #1;

    // Table of single-beat frames
    bus.res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(pack(tbl[k].ed, tbl[k].ei, tbl[k].es, tbl[k].ec));
      drive_beat(tbl[k].d, tbl[k].i, tbl[k].n, 1'b1);
    end

    // Three-beat frame with a tie on the strongest intensity
    exp_q.push_back(pack(15'd250, 5'd9, 8'd21, 4'd4));
    drive_beat(15'd100, 5'd3, 2'd1, 1'b0);
    drive_beat(15'd250, 5'd9, 2'd1, 1'b0);
    drive_beat(15'd400, 5'd9, 2'd2, 1'b1);

    // Twenty beats saturating both sums
    exp_q.push_back(pack(15'd1000, 5'd31, 8'd255, 4'd15));
    for (int k = 0; k < 20; k++)
      drive_beat(15'(1000 + k), 5'd31, 2'd3, (k == 19));

    // All-zero intensity: first beat still loads
    exp_q.push_back(pack(15'd500, 5'd0, 8'd0, 4'd1));
    drive_beat(15'd500, 5'd0, 2'd0, 1'b0);
    drive_beat(15'd600, 5'd0, 2'd1, 1'b1);

    drain();
    chk("frame_cnt_basic", 32'(frame_cnt), 32'd7);

    // Back-to-back single-beat frames with valid held high
    begin
      int k;
      k = 0;
      bus.TDC_Ovalid = 1'b1;
      bus.TDC_Olast  = 1'b1;
      bus.TDC_Onum   = 2'd1;
      bus.TDC_Odata  = 15'd2000;
      bus.TDC_Oint   = 5'd1;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        chk("b2b_oready", 32'(bus.TDC_Oready), 32'((c % 2) == 0));
        chk("b2b_frame_cnt", 32'(frame_cnt), 32'(7 + c / 2));
        if (bus.TDC_Oready)
          exp_q.push_back(pack(15'(2000 + k), 5'(k + 1), 8'(k + 1), 4'd1));
        @(posedge clk);
        #1;
        if ((c % 2) == 0) begin
          k++;
          bus.TDC_Odata = 15'(2000 + k);
          bus.TDC_Oint  = 5'(k + 1);
        end
      end
      bus.TDC_Ovalid = 1'b0;
    end
    drain();
    chk("frame_cnt_b2b", 32'(frame_cnt), 32'd11);

    // FIFO full backpressure: nine frames into eight entries
    bus.res_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      exp_q.push_back(pack(15'(3000 + k), 5'(k), 8'(k), 4'(k % 4)));
      drive_beat(15'(3000 + k), 5'(k), 2'(k % 4), 1'b1);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("full_oready",    32'(bus.TDC_Oready), 32'd0);
    chk("full_frame_cnt", 32'(frame_cnt),      32'd19);
    chk("full_res_valid", 32'(bus.res_valid),  32'd1);
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    @(negedge clk);
    chk("pop_oready_same",    32'(bus.TDC_Oready), 32'd0);
    chk("pop_frame_cnt_same", 32'(frame_cnt),      32'd19);
    @(negedge clk);
    chk("pop_oready_next",    32'(bus.TDC_Oready), 32'd1);
    chk("pop_frame_cnt_next", 32'(frame_cnt),      32'd20);
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    drain();

    // Asynchronous reset mid-frame with two words queued
    bus.res_ready = 1'b0;
    exp_q.push_back(pack(15'd4000, 5'd2, 8'd2, 4'd1));
    drive_beat(15'd4000, 5'd2, 2'd1, 1'b1);
    exp_q.push_back(pack(15'd4001, 5'd3, 8'd3, 4'd2));
    drive_beat(15'd4001, 5'd3, 2'd2, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_frame_cnt", 32'(frame_cnt), 32'd22);
    drive_beat(15'd7777, 5'd30, 2'd3, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_res_valid", 32'(bus.res_valid),  32'd0);
    chk("arst_oready",    32'(bus.TDC_Oready), 32'd0);
    chk("arst_frame_cnt", 32'(frame_cnt),      32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    exp_q.push_back(pack(15'd222, 5'd6, 8'd10, 4'd3));
    drive_beat(15'd111, 5'd4, 2'd1, 1'b0);
    drive_beat(15'd222, 5'd6, 2'd2, 1'b1);
    drain();
    chk("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
